user_obi_mgr_arb: RTL and testbench
===================================

Name: user_obi_mgr_arb

Overview:
- Round-robin arbiter sharing the single user-domain OBI manager port into the Croc domain between NumMgr user-domain managers (DMA, accelerators).
- Sits inside user_domain, directly in front of the user manager request/response pair.
- Serialises OBI address phases and routes in-order responses back to the issuing requester using a source-index queue.
- Limits outstanding transactions to MaxTrans.

Parameters:
- NumMgr, 2, number of requesting managers (>=2).
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width; byte-enable width is DataWidth/8.
- MaxTrans, 2, maximum outstanding granted-but-unanswered transactions (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- sbr_req_i  in  NumMgr  per-requester OBI req
- sbr_gnt_o  out  NumMgr  per-requester OBI gnt
- sbr_addr_i  in  NumMgr*AddrWidth  per-requester address
- sbr_we_i  in  NumMgr  per-requester write enable
- sbr_be_i  in  NumMgr*DataWidth/8  per-requester byte enables
- sbr_wdata_i  in  NumMgr*DataWidth  per-requester write data
- sbr_rvalid_o  out  NumMgr  per-requester response valid
- sbr_rdata_o  out  DataWidth  read data, broadcast to all requesters
- sbr_err_o  out  1  response error, broadcast to all requesters
- mgr_req_o  out  1  OBI req to Croc domain
- mgr_gnt_i  in  1  OBI gnt
- mgr_addr_o  out  AddrWidth  address
- mgr_we_o  out  1  write enable
- mgr_be_o  out  DataWidth/8  byte enables
- mgr_wdata_o  out  DataWidth  write data
- mgr_rvalid_i  in  1  response valid
- mgr_rdata_i  in  DataWidth  response data
- mgr_err_i  in  1  response error
- proto_err_o  out  1  sticky flag: rvalid received with no outstanding transaction

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - priority pointer = 0, lock = 0, outstanding count = 0, queue emptied, proto_err_o = 0.
  - All outputs are 0 in the cycle after reset regardless of inputs.
  - Reset mid-operation discards outstanding state; a later mgr_rvalid_i with an empty queue sets proto_err_o.
- Arbitration:
  - Combinational round-robin starting at the priority pointer; the lowest index at or after the pointer with sbr_req_i set wins.
  - mgr_req_o = (any request or lock) and not full; full means count == MaxTrans.
  - Full is evaluated on the registered count. A pop in the same cycle does not unblock issue; the new request issues next cycle.
- Address-phase stability:
  - Once mgr_req_o is high without mgr_gnt_i, lock = 1 and the winning index is stored.
  - Selection and all mgr_* address-phase outputs stay fixed until the grant, even if a higher-priority requester asserts.
- Grant:
  - sbr_gnt_o[k] = mgr_gnt_i and mgr_req_o and (selected == k); zero latency.
  - On a handshake: push k into the queue, clear lock, set pointer = (k+1) mod NumMgr.
- Response routing:
  - OBI responses are in order; the head of the queue identifies the target.
  - sbr_rvalid_o[head] = mgr_rvalid_i, combinational and same cycle; the queue is popped on mgr_rvalid_i.
  - sbr_rdata_o and sbr_err_o are passed straight through from mgr_rdata_i and mgr_err_i.
- Count update:
  - push only: +1; pop only: −1; push and pop together: unchanged.
  - Push while full is impossible because req is gated.
  - Pop while empty: sbr_rvalid_o stays 0, count stays 0, proto_err_o set (cleared only by reset).
- Idle: with no requests, mgr_* outputs are driven to 0.
- Handshake latency: request to Croc-domain OBI is 0 cycles; throughput is one transaction per cycle while not full.

Decomposition:
- Shared package (user_pkg): user_arb_req_t struct (addr, we, be, wdata) and user_arb_rsp_t struct (rdata, err), parameterised via AddrWidth/DataWidth constants; localparam for the index width $clog2(NumMgr).
- One sub-module, user_arb_idq: synchronous circular FIFO of depth MaxTrans holding requester indices. It provides push/pop, head, full/empty, and a count of width $clog2(MaxTrans+1), with pointer wrap-around at MaxTrans.

Test Plan:
- Single requester: sbr_req_i=01, addr 0x2000_0000, gnt immediate, rvalid 2 cycles later with rdata 0xDEADBEEF -> sbr_gnt_o=01 the same cycle; sbr_rvalid_o=01 with rdata 0xDEADBEEF; count returns to 0.
- Fairness: both requesters hold req continuously with gnt always high -> grants alternate 01,10,01,10 over 4 cycles; the pointer is visible as strict alternation.
- Stability: sbr_req_i=10 (pointer 0), gnt held low 3 cycles, then requester 0 asserts -> mgr_addr_o stays at requester 1's address; the grant goes to 1 first, then 0.
- Backpressure with MaxTrans=2: three back-to-back grants attempted with no rvalid -> mgr_req_o drops after 2 grants; it re-asserts the cycle after the first rvalid; responses route to the issuers in order.
- Simultaneous push and pop at count 1 -> count stays 1; rvalid goes to the older requester's index.
- Spurious rvalid after reset mid-transaction -> sbr_rvalid_o=00 and proto_err_o=1 until the next rst_i.

Source files
------------

// File: rtl/user_pkg.sv
// Shared types and constants for the user-domain OBI manager arbiter.
package user_pkg;

   localparam int unsigned ArbNumMgr    = 2;
   localparam int unsigned ArbAddrWidth = 32;
   localparam int unsigned ArbDataWidth = 32;
   localparam int unsigned ArbBeWidth   = ArbDataWidth / 8;
   localparam int unsigned ArbIdxWidth  = $clog2(ArbNumMgr);

   typedef struct packed {
      logic [ArbAddrWidth-1:0] addr;
      logic                    we;
      logic [ArbBeWidth-1:0]   be;
      logic [ArbDataWidth-1:0] wdata;
   } user_arb_req_t;

   typedef struct packed {
      logic [ArbDataWidth-1:0] rdata;
      logic                    err;
   } user_arb_rsp_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_e;

   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/user_arb_idq.sv
// In-order queue of requester indices for granted transactions awaiting a response.
module user_arb_idq #(
   parameter int unsigned Depth = 2,
   parameter int unsigned IdxW  = 1,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  logic [IdxW-1:0] push_idx_i,
   input  logic            pop_i,
   output logic [IdxW-1:0] head_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [IdxW-1:0] mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            do_push_c, do_pop_c;

   assign full_o    = (cnt_q == CntW'(Depth));
   assign empty_o   = (cnt_q == '0);
   assign count_o   = cnt_q;
   assign head_o    = mem_q[rd_ptr_q];
   assign do_push_c = push_i & ~full_o;
   assign do_pop_c  = pop_i & ~empty_o;

   // pointers wrap at Depth, which need not be a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push_c) begin
         wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop_c) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({do_push_c, do_pop_c})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && do_push_c) begin
         mem_q[wr_ptr_q] <= push_idx_i;
      end
   end

endmodule

// File: rtl/user_obi_mgr_arb.sv
// Round-robin arbiter sharing the user-domain OBI manager port among NumMgr managers,
// with in-order response routing and a cap on outstanding transactions.
module user_obi_mgr_arb
   import user_pkg::*;
#(
   parameter int unsigned NumMgr    = 2,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned MaxTrans  = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NumMgr-1:0]                 sbr_req_i,
   output logic [NumMgr-1:0]                 sbr_gnt_o,
   input  logic [NumMgr*AddrWidth-1:0]       sbr_addr_i,
   input  logic [NumMgr-1:0]                 sbr_we_i,
   input  logic [NumMgr*(DataWidth/8)-1:0]   sbr_be_i,
   input  logic [NumMgr*DataWidth-1:0]       sbr_wdata_i,
   output logic [NumMgr-1:0]                 sbr_rvalid_o,
   output logic [DataWidth-1:0]              sbr_rdata_o,
   output logic                              sbr_err_o,
   output logic                              mgr_req_o,
   input  logic                              mgr_gnt_i,
   output logic [AddrWidth-1:0]              mgr_addr_o,
   output logic                              mgr_we_o,
   output logic [DataWidth/8-1:0]            mgr_be_o,
   output logic [DataWidth-1:0]              mgr_wdata_o,
   input  logic                              mgr_rvalid_i,
   input  logic [DataWidth-1:0]              mgr_rdata_i,
   input  logic                              mgr_err_i,
   output logic                              proto_err_o
);

   localparam int unsigned IdxW = $clog2(NumMgr);
   localparam int unsigned BeW  = DataWidth / 8;
   localparam int unsigned CntW = $clog2(MaxTrans + 1);

   arb_state_e      state_q, state_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] hold_idx_q, hold_idx_d;
   logic [IdxW-1:0] win_c, sel_c, head_c;
   logic [CntW-1:0] cnt_c;
   logic            rst_q, quiet_c;
   logic            full_c, empty_c;
   logic            any_req_c, req_c, push_c, pop_c;
   logic            proto_err_q, proto_err_d;
   user_arb_req_t   req_pl [NumMgr];
   user_arb_req_t   sel_req_c;
   user_arb_rsp_t   rsp_c;

   // outputs stay silent while reset is applied and for the cycle after it
   assign quiet_c = rst_i | rst_q;

   for (genvar g = 0; g < NumMgr; g++) begin : g_mgr
      assign req_pl[g] = {ArbAddrWidth'(sbr_addr_i[g*AddrWidth +: AddrWidth]),
                          sbr_we_i[g],
                          ArbBeWidth'(sbr_be_i[g*BeW +: BeW]),
                          ArbDataWidth'(sbr_wdata_i[g*DataWidth +: DataWidth])};
      assign sbr_gnt_o[g]    = push_c & (sel_c == IdxW'(g));
      assign sbr_rvalid_o[g] = pop_c & ~quiet_c & (head_c == IdxW'(g));
   end

   // round-robin search: first requester at or after the priority pointer
   always_comb begin
      logic [IdxW-1:0] cand;
      logic            found;
      win_c = ptr_q;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NumMgr; i++) begin
         cand = IdxW'((32'(ptr_q) + i) % NumMgr);
         if (!found && sbr_req_i[cand]) begin
            win_c = cand;
            found = 1'b1;
         end
      end
   end

   // selection is frozen from an ungranted request until its grant
   always_comb begin
      state_d    = state_q;
      hold_idx_d = hold_idx_q;
      ptr_d      = ptr_q;
      sel_c      = (state_q == ARB_HOLD) ? hold_idx_q : win_c;
      any_req_c  = (|sbr_req_i) | (state_q == ARB_HOLD);
      req_c      = any_req_c & ~full_c & ~quiet_c;
      push_c     = req_c & mgr_gnt_i;
      if (push_c) begin
         state_d = ARB_IDLE;
         ptr_d   = IdxW'(wrap_inc(32'(sel_c), NumMgr));
      end else if (req_c) begin
         state_d    = ARB_HOLD;
         hold_idx_d = sel_c;
      end
   end

   assign pop_c       = mgr_rvalid_i & ~empty_c;
   assign proto_err_d = proto_err_q | (mgr_rvalid_i & (cnt_c == '0));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rst_q       <= 1'b1;
         state_q     <= ARB_IDLE;
         ptr_q       <= '0;
         hold_idx_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         rst_q       <= 1'b0;
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_idx_q  <= hold_idx_d;
         proto_err_q <= proto_err_d;
      end
   end

   user_arb_idq #(
      .Depth (MaxTrans),
      .IdxW  (IdxW)
   ) u_idq (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (push_c),
      .push_idx_i (sel_c),
      .pop_i      (pop_c),
      .head_o     (head_c),
      .full_o     (full_c),
      .empty_o    (empty_c),
      .count_o    (cnt_c)
   );

   assign sel_req_c   = req_pl[sel_c];
   assign mgr_req_o   = req_c;
   assign mgr_addr_o  = req_c ? AddrWidth'(sel_req_c.addr)  : '0;
   assign mgr_we_o    = req_c & sel_req_c.we;
   assign mgr_be_o    = req_c ? BeW'(sel_req_c.be)          : '0;
   assign mgr_wdata_o = req_c ? DataWidth'(sel_req_c.wdata) : '0;

   assign rsp_c       = {ArbDataWidth'(mgr_rdata_i), mgr_err_i};
   assign sbr_rdata_o = quiet_c ? '0 : DataWidth'(rsp_c.rdata);
   assign sbr_err_o   = ~quiet_c & rsp_c.err;
   assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_user_obi_mgr_arb.sv
// Cycle-table bench for user_obi_mgr_arb with a response-routing scoreboard.
module tb_user_obi_mgr_arb;

   localparam int unsigned N  = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;

   localparam logic [31:0] A0  = 32'h2000_0000;
   localparam logic [31:0] A1  = 32'h3000_0010;
   localparam logic [31:0] WD0 = 32'h1111_0000;
   localparam logic [31:0] WD1 = 32'h2222_0000;
   localparam logic [3:0]  BE0 = 4'hF;
   localparam logic [3:0]  BE1 = 4'h3;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [N-1:0]      sbr_req_i, sbr_gnt_o, sbr_we_i, sbr_rvalid_o;
   logic [N*AW-1:0]   sbr_addr_i;
   logic [N*BW-1:0]   sbr_be_i;
   logic [N*DW-1:0]   sbr_wdata_i;
   logic [DW-1:0]     sbr_rdata_o, mgr_wdata_o, mgr_rdata_i;
   logic              sbr_err_o, mgr_req_o, mgr_gnt_i, mgr_we_o;
   logic [AW-1:0]     mgr_addr_o;
   logic [BW-1:0]     mgr_be_o;
   logic              mgr_rvalid_i, mgr_err_i, proto_err_o;

   always #5 clk_i = ~clk_i;

   user_obi_mgr_arb #(
      .NumMgr    (N),
      .AddrWidth (AW),
      .DataWidth (DW),
      .MaxTrans  (2)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .sbr_req_i    (sbr_req_i),
      .sbr_gnt_o    (sbr_gnt_o),
      .sbr_addr_i   (sbr_addr_i),
      .sbr_we_i     (sbr_we_i),
      .sbr_be_i     (sbr_be_i),
      .sbr_wdata_i  (sbr_wdata_i),
      .sbr_rvalid_o (sbr_rvalid_o),
      .sbr_rdata_o  (sbr_rdata_o),
      .sbr_err_o    (sbr_err_o),
      .mgr_req_o    (mgr_req_o),
      .mgr_gnt_i    (mgr_gnt_i),
      .mgr_addr_o   (mgr_addr_o),
      .mgr_we_o     (mgr_we_o),
      .mgr_be_o     (mgr_be_o),
      .mgr_wdata_o  (mgr_wdata_o),
      .mgr_rvalid_i (mgr_rvalid_i),
      .mgr_rdata_i  (mgr_rdata_i),
      .mgr_err_i    (mgr_err_i),
      .proto_err_o  (proto_err_o)
   );

   typedef struct {
      logic [1:0]  req;
      logic        gnt;
      logic        rv;
      logic        err;
      logic [31:0] rdata;
      logic        exp_mreq;
      int          exp_sel;
   } vec_t;

   vec_t vecs[$];
   int   sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic vec_t mk(input logic [1:0] req, input logic gnt, input logic rv,
                               input logic err, input logic [31:0] rdata,
                               input logic exp_mreq, input int exp_sel);
      vec_t v;
      v.req = req; v.gnt = gnt; v.rv = rv; v.err = err; v.rdata = rdata;
      v.exp_mreq = exp_mreq; v.exp_sel = exp_sel;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // drive one cycle of inputs, then compare all outputs mid-cycle
   task automatic apply(input vec_t v, input string tag, input logic quiet, input logic exp_proto);
      logic [1:0]  eg, erv;
      logic [31:0] ea, ewd;
      logic        ewe;
      logic [3:0]  ebe;
      sbr_req_i    = v.req;
      mgr_gnt_i    = v.gnt;
      mgr_rvalid_i = v.rv;
      mgr_err_i    = v.err;
      mgr_rdata_i  = v.rdata;
      #4;
      eg = '0; erv = '0; ea = '0; ewd = '0; ewe = 1'b0; ebe = '0;
      if (v.exp_mreq && !quiet) begin
         ea  = (v.exp_sel == 1) ? A1  : A0;
         ewd = (v.exp_sel == 1) ? WD1 : WD0;
         ebe = (v.exp_sel == 1) ? BE1 : BE0;
         ewe = (v.exp_sel == 0);
         if (v.gnt) eg = 2'(1 << v.exp_sel);
      end
      if (v.rv && !quiet && sb.size() > 0) erv = 2'(1 << sb.pop_front());
      if (eg != '0) sb.push_back(v.exp_sel);
      chk({tag, ".gnt"},    64'(sbr_gnt_o),    64'(eg));
      chk({tag, ".req"},    64'(mgr_req_o),    64'(v.exp_mreq && !quiet));
      chk({tag, ".addr"},   64'(mgr_addr_o),   64'(ea));
      chk({tag, ".we"},     64'(mgr_we_o),     64'(ewe));
      chk({tag, ".be"},     64'(mgr_be_o),     64'(ebe));
      chk({tag, ".wdata"},  64'(mgr_wdata_o),  64'(ewd));
      chk({tag, ".rvalid"}, 64'(sbr_rvalid_o), 64'(erv));
      chk({tag, ".rdata"},  64'(sbr_rdata_o),  quiet ? 64'd0 : 64'(v.rdata));
      chk({tag, ".err"},    64'(sbr_err_o),    64'(v.err && !quiet));
      chk({tag, ".proto"},  64'(proto_err_o),  64'(exp_proto));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      sbr_addr_i   = {A1, A0};
      sbr_we_i     = 2'b01;
      sbr_be_i     = {BE1, BE0};
      sbr_wdata_i  = {WD1, WD0};
      rst_i        = 1'b1;
      sbr_req_i    = '0;
      mgr_gnt_i    = 1'b0;
      mgr_rvalid_i = 1'b0;
      mgr_err_i    = 1'b0;
      mgr_rdata_i  = '0;

      // single requester, response two cycles after grant
      vecs.push_back(mk(2'b01, 1, 0, 0, 32'h0,         1, 0));
      vecs.push_back(mk(2'b00, 0, 0, 0, 32'h0,         0, 0));
      vecs.push_back(mk(2'b00, 0, 1, 0, 32'hDEADBEEF,  0, 0));
      // fairness with overlapping push/pop at count 1
      vecs.push_back(mk(2'b11, 1, 0, 0, 32'h0,         1, 1));
      vecs.push_back(mk(2'b11, 1, 1, 0, 32'h0000_1111, 1, 0));
      vecs.push_back(mk(2'b11, 1, 1, 0, 32'hA5A5_0006, 1, 1));
      vecs.push_back(mk(2'b11, 1, 1, 0, 32'h0000_0007, 1, 0));
      vecs.push_back(mk(2'b00, 0, 1, 0, 32'h0000_0008, 0, 0));
      // move pointer back to 0
      vecs.push_back(mk(2'b10, 1, 0, 0, 32'h0,         1, 1));
      vecs.push_back(mk(2'b00, 0, 1, 0, 32'h0000_000A, 0, 0));
      // address-phase stability under a late higher-priority request
      vecs.push_back(mk(2'b10, 0, 0, 0, 32'h0,         1, 1));
      vecs.push_back(mk(2'b10, 0, 0, 0, 32'h0,         1, 1));
      vecs.push_back(mk(2'b10, 0, 0, 0, 32'h0,         1, 1));
      vecs.push_back(mk(2'b11, 0, 0, 0, 32'h0,         1, 1));
      vecs.push_back(mk(2'b11, 1, 0, 0, 32'h0,         1, 1));
      vecs.push_back(mk(2'b11, 1, 0, 0, 32'h0,         1, 0));
      vecs.push_back(mk(2'b00, 0, 1, 0, 32'h0000_0011, 0, 0));
      vecs.push_back(mk(2'b00, 0, 1, 0, 32'h0000_0012, 0, 0));
      // backpressure at MaxTrans=2
      vecs.push_back(mk(2'b11, 1, 0, 0, 32'h0,         1, 1));
      vecs.push_back(mk(2'b11, 1, 0, 0, 32'h0,         1, 0));
      vecs.push_back(mk(2'b11, 1, 0, 0, 32'h0,         0, 0));
      vecs.push_back(mk(2'b11, 1, 1, 0, 32'h0000_0016, 0, 0));
      vecs.push_back(mk(2'b11, 1, 0, 0, 32'h0,         1, 1));
      vecs.push_back(mk(2'b00, 0, 1, 1, 32'h0000_0018, 0, 0));
      vecs.push_back(mk(2'b00, 0, 1, 0, 32'h0000_0019, 0, 0));

      @(posedge clk_i);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      apply(mk(2'b11, 1, 0, 1, 32'hFFFF_FFFF, 0, 0), "post_reset", 1, 0);

      foreach (vecs[i]) begin
         @(posedge clk_i); #1;
         apply(vecs[i], $sformatf("row%0d", i), 0, 0);
      end

      // reset while a transaction is outstanding, then a spurious response
      @(posedge clk_i); #1;
      apply(mk(2'b01, 1, 0, 0, 32'h0, 1, 0), "mid_gnt", 0, 0);
      @(posedge clk_i); #1 rst_i = 1'b1;
      apply(mk(2'b11, 1, 0, 0, 32'h0, 0, 0), "in_reset", 1, 0);
      @(posedge clk_i); #1 rst_i = 1'b0;
      sb.delete();
      apply(mk(2'b00, 0, 0, 0, 32'h0, 0, 0), "after_rst", 1, 0);
      @(posedge clk_i); #1;
      apply(mk(2'b00, 0, 1, 0, 32'h1234_5678, 0, 0), "spurious", 0, 0);
      @(posedge clk_i); #1;
      apply(mk(2'b00, 0, 0, 0, 32'h0, 0, 0), "proto_set", 0, 1);
      @(posedge clk_i); #1;
      apply(mk(2'b01, 1, 0, 0, 32'h0, 1, 0), "proto_hold_gnt", 0, 1);
      @(posedge clk_i); #1;
      apply(mk(2'b00, 0, 1, 0, 32'hCAFE_0001, 0, 0), "proto_hold_rsp", 0, 1);
      @(posedge clk_i); #1 rst_i = 1'b1;
      apply(mk(2'b00, 0, 0, 0, 32'h0, 0, 0), "reset2", 1, 1);
      @(posedge clk_i); #1 rst_i = 1'b0;
      sb.delete();
      apply(mk(2'b00, 0, 0, 0, 32'h0, 0, 0), "after_rst2", 1, 0);
      @(posedge clk_i); #1;
      apply(mk(2'b10, 1, 0, 0, 32'h0, 1, 1), "proto_clear", 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
